// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port byte-masked SRAM arbiter.
// Build option: define SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority
// instead of round-robin.
package sram_arb_pkg;

  localparam int SRAM_DATAW = 32;
  localparam int SRAM_ADDRW = 7;
  localparam int SRAM_STRBW = SRAM_DATAW / 8;
  localparam int NPORTS     = 2;

  typedef logic [0:0] port_idx_t;

  // One requester's access as presented to the SRAM.
  typedef struct packed {
    logic                  wren;
    logic [SRAM_ADDRW-1:0] addr;
    logic [SRAM_DATAW-1:0] data;
    logic [SRAM_STRBW-1:0] strb;
  } req_t;

  // Pick a port from the eligible set; tie decides when both are eligible.
  function automatic port_idx_t pick_port(input logic [NPORTS-1:0] elig,
                                          input port_idx_t         tie);
    if (elig[0] && elig[1]) return tie;
    else if (elig[1])       return 1'b1;
    else                    return 1'b0;
  endfunction

endpackage

// File: rtl/sram_arb_resp_buf.sv
// One-entry response slot for one requester. A response arriving from the
// SRAM is presented immediately (bypass) and captured only if the requester
// does not take it that cycle, so a ready requester sees no extra latency.
// occ marks the slot as reserved from request accept until the response is
// consumed.
module sram_arb_resp_buf
  import sram_arb_pkg::*;
#(
  parameter int DATAW = SRAM_DATAW
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic             reserve,
  input  logic             fill,
  input  logic [DATAW-1:0] fill_data,
  input  logic             rready,
  output logic             rvalid,
  output logic [DATAW-1:0] rdata,
  output logic             occ
);

  logic             buf_vld;
  logic [DATAW-1:0] buf_data;
  logic             drain;

  // fill and buf_vld never coincide: occ limits each port to one outstanding response.
  assign rvalid = buf_vld | fill;
  assign rdata  = buf_vld ? buf_data : fill_data;
  assign drain  = rvalid & rready;

  // Capture an untaken response and track the slot reservation.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      buf_vld  <= 1'b0;
      buf_data <= '0;
      occ      <= 1'b0;
    end else begin
      if (fill && !rready) begin
        buf_vld  <= 1'b1;
        buf_data <= fill_data;
      end else if (drain) begin
        buf_vld  <= 1'b0;
      end
      if (reserve)    occ <= 1'b1;
      else if (drain) occ <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_mask_sram_arbiter.sv
// Two-port arbiter in front of a synchronous byte-masked SRAM with one-cycle
// read latency. Grants one request per cycle, remembers who issued it and
// routes the SRAM data back into that port's response slot.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// ties); default is round-robin on handshakes.
// The DATAW/ADDRW parameters must match the widths of req_t in sram_arb_pkg.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid && ready. valid and its payload stay stable until that edge;
// ready may depend combinationally on valid. pN_aready is driven
// combinationally from the grant and mem_aready.
module byte_mask_sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATAW = SRAM_DATAW,
  parameter int ADDRW = SRAM_ADDRW
) (
  input  logic               clk,
  input  logic               rstx,
  input  logic               p0_avalid,
  output logic               p0_aready,
  input  logic               p0_awren,
  input  logic [ADDRW-1:0]   p0_aaddr,
  input  logic [DATAW-1:0]   p0_adata,
  input  logic [DATAW/8-1:0] p0_astrb,
  output logic               p0_rvalid,
  input  logic               p0_rready,
  output logic [DATAW-1:0]   p0_rdata,
  input  logic               p1_avalid,
  output logic               p1_aready,
  input  logic               p1_awren,
  input  logic [ADDRW-1:0]   p1_aaddr,
  input  logic [DATAW-1:0]   p1_adata,
  input  logic [DATAW/8-1:0] p1_astrb,
  output logic               p1_rvalid,
  input  logic               p1_rready,
  output logic [DATAW-1:0]   p1_rdata,
  output logic               mem_avalid,
  output logic               mem_awren,
  output logic [ADDRW-1:0]   mem_aaddr,
  output logic [DATAW-1:0]   mem_adata,
  output logic [DATAW/8-1:0] mem_astrb,
  input  logic               mem_aready,
  input  logic [DATAW-1:0]   mem_rdata,
  output logic               mem_rready
);

  req_t [NPORTS-1:0] req;
  req_t              sel_req;
  logic [NPORTS-1:0] avalid, rvalid, rready, occ, elig, fill;
  logic              gnt_vld;
  port_idx_t         gnt_port;
  port_idx_t         tie_port;
  logic              lock_vld;
  port_idx_t         lock_port;
  logic              issue_vld;
  port_idx_t         issue_port;

  assign req[0] = '{wren: p0_awren, addr: p0_aaddr, data: p0_adata, strb: p0_astrb};
  assign req[1] = '{wren: p1_awren, addr: p1_aaddr, data: p1_adata, strb: p1_astrb};

  assign avalid    = {p1_avalid, p0_avalid};
  assign rready    = {p1_rready, p0_rready};
  assign rvalid    = {p1_rvalid, p0_rvalid};

  // A port may issue when its slot is free or is being emptied this cycle.
  assign elig = avalid & (~occ | (rvalid & rready));

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign tie_port = 1'b0;
`else
  port_idx_t last_grant;

  // Remember the last port that completed a handshake; the other one wins ties.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx)                          last_grant <= 1'b1;
    else if (gnt_vld && mem_aready)     last_grant <= gnt_port;
  end

  assign tie_port = ~last_grant;
`endif

  // Grant selection; a stalled request keeps its grant until the SRAM takes it.
  always_comb begin
    gnt_vld  = |elig;
    gnt_port = pick_port(elig, tie_port);
    if (lock_vld && elig[lock_port]) begin
      gnt_port = lock_port;
    end
  end

  assign sel_req    = req[gnt_port];
  assign mem_avalid = gnt_vld;
  assign mem_awren  = sel_req.wren;
  assign mem_aaddr  = sel_req.addr;
  assign mem_adata  = sel_req.data;
  assign mem_astrb  = sel_req.strb;
  assign mem_rready = 1'b1;

  assign p0_aready = gnt_vld && (gnt_port == 1'b0) && mem_aready;
  assign p1_aready = gnt_vld && (gnt_port == 1'b1) && mem_aready;

  // Track a stalled grant and the port whose response the SRAM returns next cycle.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      lock_vld   <= 1'b0;
      lock_port  <= '0;
      issue_vld  <= 1'b0;
      issue_port <= '0;
    end else begin
      lock_vld   <= gnt_vld && !mem_aready;
      lock_port  <= gnt_port;
      issue_vld  <= gnt_vld && mem_aready;
      issue_port <= gnt_port;
    end
  end

  assign fill[0] = issue_vld && (issue_port == 1'b0);
  assign fill[1] = issue_vld && (issue_port == 1'b1);

  sram_arb_resp_buf #(.DATAW(DATAW)) u_rbuf0 (
    .clk       (clk),
    .rstx      (rstx),
    .reserve   (p0_aready),
    .fill      (fill[0]),
    .fill_data (mem_rdata),
    .rready    (p0_rready),
    .rvalid    (p0_rvalid),
    .rdata     (p0_rdata),
    .occ       (occ[0])
  );

  sram_arb_resp_buf #(.DATAW(DATAW)) u_rbuf1 (
    .clk       (clk),
    .rstx      (rstx),
    .reserve   (p1_aready),
    .fill      (fill[1]),
    .fill_data (mem_rdata),
    .rready    (p1_rready),
    .rvalid    (p1_rvalid),
    .rdata     (p1_rdata),
    .occ       (occ[1])
  );

endmodule

// File: tb/tb_byte_mask_sram_arbiter.sv
// Bench for byte_mask_sram_arbiter: SRAM model, one request driver per port,
// per-port response monitors against expected queues, directed tests.
// Honours SRAM_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_byte_mask_sram_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [DW-1:0] exp;
  } tb_req_t;

  logic          clk = 1'b0;
  logic          rstx;
  logic          p0_avalid, p0_aready, p0_awren, p0_rvalid, p0_rready;
  logic [AW-1:0] p0_aaddr;
  logic [DW-1:0] p0_adata, p0_rdata;
  logic [SW-1:0] p0_astrb;
  logic          p1_avalid, p1_aready, p1_awren, p1_rvalid, p1_rready;
  logic [AW-1:0] p1_aaddr;
  logic [DW-1:0] p1_adata, p1_rdata;
  logic [SW-1:0] p1_astrb;
  logic          mem_avalid, mem_awren, mem_aready, mem_rready;
  logic [AW-1:0] mem_aaddr;
  logic [DW-1:0] mem_adata, mem_rdata;
  logic [SW-1:0] mem_astrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tb_req_t       rq0[$], rq1[$];
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  logic          grant_log[$];
  int            acc_cyc[$];
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] sram    [0:127];
  logic          sram_loaded = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  byte_mask_sram_arbiter dut (
    .clk(clk), .rstx(rstx),
    .p0_avalid(p0_avalid), .p0_aready(p0_aready), .p0_awren(p0_awren),
    .p0_aaddr(p0_aaddr), .p0_adata(p0_adata), .p0_astrb(p0_astrb),
    .p0_rvalid(p0_rvalid), .p0_rready(p0_rready), .p0_rdata(p0_rdata),
    .p1_avalid(p1_avalid), .p1_aready(p1_aready), .p1_awren(p1_awren),
    .p1_aaddr(p1_aaddr), .p1_adata(p1_adata), .p1_astrb(p1_astrb),
    .p1_rvalid(p1_rvalid), .p1_rready(p1_rready), .p1_rdata(p1_rdata),
    .mem_avalid(mem_avalid), .mem_awren(mem_awren), .mem_aaddr(mem_aaddr),
    .mem_adata(mem_adata), .mem_astrb(mem_astrb), .mem_aready(mem_aready),
    .mem_rdata(mem_rdata), .mem_rready(mem_rready)
  );

  function automatic logic [DW-1:0] pattern(input int a);
    if (a == 16) return 32'h1122_3344;
    return (32'h0101_0101 * a) ^ 32'hA500_0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < SW; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // SRAM model: data for an accepted request appears the following cycle.
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 128; i++) sram[i] <= pattern(i);
      sram_loaded <= 1'b1;
    end else if (rstx && mem_avalid && mem_aready) begin
      if (mem_awren) begin
        sram[mem_aaddr] <= merge(sram[mem_aaddr], mem_adata, mem_astrb);
        mem_rdata       <= merge(sram[mem_aaddr], mem_adata, mem_astrb);
      end else begin
        mem_rdata <= sram[mem_aaddr];
      end
    end else begin
      mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // driver task: queue a request; expected response comes from the reference memory
  task automatic enq(input int port, input logic wren, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input logic [SW-1:0] strb,
                     input logic use_hand, input logic [DW-1:0] hand);
    tb_req_t r;
    r.wren = wren; r.addr = addr; r.data = data; r.strb = strb;
    r.exp  = wren ? merge(ref_mem[addr], data, strb) : ref_mem[addr];
    if (wren) ref_mem[addr] = r.exp;
    if (use_hand) r.exp = hand;
    if (port == 0) rq0.push_back(r);
    else           rq1.push_back(r);
  endtask

  task automatic rd(input int port, input logic [AW-1:0] addr);
    enq(port, 1'b0, addr, '0, '0, 1'b0, '0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || exp_q0.size() != 0 || exp_q1.size() != 0)
           && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s timeout: actual=still_busy required=idle within %0d cycles", name, budget);
    end
  endtask

  // Port 0 driver: present queue head, log accept at negedge, retire at next edge.
  logic acc0 = 1'b0;
  always begin
    @(posedge clk);
    if (acc0) begin rq0.delete(0); acc0 = 1'b0; end
    #1;
    if (rq0.size() != 0) begin
      p0_avalid = 1'b1; p0_awren = rq0[0].wren; p0_aaddr = rq0[0].addr;
      p0_adata = rq0[0].data; p0_astrb = rq0[0].strb;
    end else begin
      p0_avalid = 1'b0;
    end
    @(negedge clk);
    if (p0_avalid && p0_aready) begin
      acc0 = 1'b1;
      exp_q0.push_back(rq0[0].exp);
      grant_log.push_back(1'b0);
      acc_cyc.push_back(cyc);
    end
  end

  // Port 1 driver.
  logic acc1 = 1'b0;
  always begin
    @(posedge clk);
    if (acc1) begin rq1.delete(0); acc1 = 1'b0; end
    #1;
    if (rq1.size() != 0) begin
      p1_avalid = 1'b1; p1_awren = rq1[0].wren; p1_aaddr = rq1[0].addr;
      p1_adata = rq1[0].data; p1_astrb = rq1[0].strb;
    end else begin
      p1_avalid = 1'b0;
    end
    @(negedge clk);
    if (p1_avalid && p1_aready) begin
      acc1 = 1'b1;
      exp_q1.push_back(rq1[0].exp);
      grant_log.push_back(1'b1);
      acc_cyc.push_back(cyc);
    end
  end

  // Scoreboard monitors: compare on each response handshake, check hold while stalled.
  logic          hold0 = 1'b0, hold1 = 1'b0;
  logic [DW-1:0] held0, held1;
  always @(negedge clk) begin
    if (!rstx) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        chk("p0_hold_rvalid", p0_rvalid, 1);
        chk("p0_hold_rdata", p0_rdata, held0);
      end
      hold0 = 1'b0;
      if (p0_rvalid && p0_rready) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL p0_unexpected_resp actual=%h required=no_response", p0_rdata);
        end else begin
          chk("p0_rdata", p0_rdata, exp_q0.pop_front());
        end
      end else if (p0_rvalid) begin
        hold0 = 1'b1; held0 = p0_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstx) begin
      hold1 = 1'b0;
    end else begin
      if (hold1) begin
        chk("p1_hold_rvalid", p1_rvalid, 1);
        chk("p1_hold_rdata", p1_rdata, held1);
      end
      hold1 = 1'b0;
      if (p1_rvalid && p1_rready) begin
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL p1_unexpected_resp actual=%h required=no_response", p1_rdata);
        end else begin
          chk("p1_rdata", p1_rdata, exp_q1.pop_front());
        end
      end else if (p1_rvalid) begin
        hold1 = 1'b1; held1 = p1_rdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic e;
    rstx = 1'b0; mem_aready = 1'b1;
    p0_rready = 1'b1; p1_rready = 1'b1;
    p0_avalid = 1'b0; p0_awren = 1'b0; p0_aaddr = '0; p0_adata = '0; p0_astrb = '0;
    p1_avalid = 1'b0; p1_awren = 1'b0; p1_aaddr = '0; p1_adata = '0; p1_astrb = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = pattern(i);
    repeat (3) @(posedge clk);
    #2 rstx = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_mem_avalid", mem_avalid, 0);
    chk("rst_mem_rready", mem_rready, 1);

    // 1: single read, same-cycle accept, response next cycle
    tick();
    rd(0, 7'h05);
    tick();
    @(negedge clk);
    chk("t1_p0_aready", p0_aready, 1);
    chk("t1_mem_aaddr", mem_aaddr, 7'h05);
    @(negedge clk);
    chk("t1_p0_rvalid", p0_rvalid, 1);
    chk("t1_p1_rvalid", p1_rvalid, 0);
    wait_idle("t1", 20);
    rd(1, 7'h06);
    wait_idle("t1b", 20);

    // 2: both ports stream reads
    grant_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      rd(0, 7'h30 + 7'(i));
      rd(1, 7'h38 + 7'(i));
    end
    wait_idle("t2", 50);
    chk("t2_grant_count", grant_log.size(), 8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        e = (i >= 4);
`else
        e = i[0];
`endif
        chk($sformatf("t2_grant_%0d", i), grant_log[i], e);
        if (i > 0) chk($sformatf("t2_back_to_back_%0d", i), acc_cyc[i] - acc_cyc[i-1], 1);
      end
    end

    // 3: stalled p1 response does not block p0
    tick();
    p1_rready = 1'b0;
    rd(1, 7'h40);
    rd(1, 7'h41);
    repeat (3) tick();
    chk("t3_p1_pending", p1_rvalid, 1);
    grant_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) rd(0, 7'h50 + 7'(i));
    n = 0;
    while (rq0.size() != 0 && n < 30) begin tick(); n++; end
    chk("t3_p0_done", rq0.size(), 0);
    chk("t3_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_grant_%0d", i), grant_log[i], 0);
        if (i > 0) chk($sformatf("t3_back_to_back_%0d", i), acc_cyc[i] - acc_cyc[i-1], 1);
      end
    end
    tick();
    p1_rready = 1'b1;
    @(negedge clk);
    chk("t3_p1_drain", p1_rvalid, 1);
    chk("t3_p1_issue_same_cycle", p1_aready, 1);
    wait_idle("t3", 30);

    // 4: byte-masked write then read back from the other port
    enq(0, 1'b1, 7'h10, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h11BB_33DD);
    wait_idle("t4w", 20);
    enq(1, 1'b0, 7'h10, '0, '0, 1'b1, 32'h11BB_33DD);
    wait_idle("t4r", 20);

    // 5: SRAM stall locks the grant on the port that got it first
    tick();
    mem_aready = 1'b0;
    grant_log.delete();
    rd(1, 7'h21);
    tick();
    rd(0, 7'h22);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t5_stall%0d_mem_avalid", s), mem_avalid, 1);
      chk($sformatf("t5_stall%0d_mem_aaddr", s), mem_aaddr, 7'h21);
      chk($sformatf("t5_stall%0d_p0_aready", s), p0_aready, 0);
      chk($sformatf("t5_stall%0d_p1_aready", s), p1_aready, 0);
    end
    tick();
    mem_aready = 1'b1;
    @(negedge clk);
    chk("t5_release_p1_aready", p1_aready, 1);
    chk("t5_release_p0_aready", p0_aready, 0);
    wait_idle("t5", 20);
    chk("t5_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t5_grant_0", grant_log[0], 1);
      chk("t5_grant_1", grant_log[1], 0);
    end

    // 6: reset with a response pending, then a contested cycle
    tick();
    p0_rready = 1'b0;
    grant_log.delete();
    rd(0, 7'h60);
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    chk("t6_accepted", grant_log.size(), 1);
    repeat (2) tick();
    chk("t6_p0_pending", p0_rvalid, 1);
    tick();
    rstx = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    chk("t6_rst_p0_rvalid", p0_rvalid, 0);
    chk("t6_rst_p1_rvalid", p1_rvalid, 0);
    repeat (2) tick();
    rstx = 1'b1;
    p0_rready = 1'b1;
    grant_log.delete();
    rd(0, 7'h61);
    rd(1, 7'h62);
    wait_idle("t6", 20);
    chk("t6_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t6_first_grant", grant_log[0], 0);
      chk("t6_second_grant", grant_log[1], 1);
    end

    repeat (3) tick();
    chk("end_exp_q0_empty", exp_q0.size(), 0);
    chk("end_exp_q1_empty", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
